detector_paso: RTL and testbench

DETECTOR_PASO -- requirements
Module: detector_paso

---
 rtl/detector_paso.sv | 212 +++++++++++++++++++++
 tb/tb_detector_paso.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_paso.sv
`default_nettype none
// ============================================================================
// Module      : detector_paso
// Description : Vehicle passage detector for a two-beam parking gate.
//               Both beams are synchronized and debounced, then an FSM
//               follows the beam pattern to tell a vehicle entering from
//               one leaving, issuing a one-cycle pulse per completed pass.
//               Illegal patterns and stalls (dwell timeout) pulse error and
//               park the FSM in ESPERA until both beams are clear.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous reset, active low
//   sensor_a in   1  outer beam, 1 = blocked, asynchronous
//   sensor_b in   1  inner beam, 1 = blocked, asynchronous
//   entrada  out  1  one-cycle pulse per completed entry
//   salida   out  1  one-cycle pulse per completed exit
//   error    out  1  one-cycle pulse on illegal sequence or timeout
//   estado   out  3  current FSM state (debug)
// ============================================================================
module detector_paso #(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic       entrada,
  output logic       salida,
  output logic       error,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    E1     = 3'd1,
    E2     = 3'd2,
    E3     = 3'd3,
    S1     = 3'd4,
    S2     = 3'd5,
    S3     = 3'd6,
    ESPERA = 3'd7
  } state_t;

  // Counter values at which the next cycle completes the wait.
  localparam logic [7:0]  DEB_LAST   = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] DWELL_LAST = 16'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Two-flop synchronizers
  // --------------------------------------------------------------------------
  logic a_meta_q, a_sync_q, b_meta_q, b_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
    end else begin
      a_meta_q <= sensor_a;
      a_sync_q <= a_meta_q;
      b_meta_q <= sensor_b;
      b_sync_q <= b_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debouncers: the counter runs only while the synchronized value disagrees
  // with the accepted one, so any disagreement shorter than DEB_CYCLES is lost.
  // --------------------------------------------------------------------------
  logic       deb_a_q, deb_b_q;
  logic [7:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_a_q <= 1'b0;
      cnt_a_q <= '0;
    end else if (a_sync_q == deb_a_q) begin
      cnt_a_q <= '0;
    end else if (cnt_a_q == DEB_LAST) begin
      deb_a_q <= a_sync_q;
      cnt_a_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_b_q <= 1'b0;
      cnt_b_q <= '0;
    end else if (b_sync_q == deb_b_q) begin
      cnt_b_q <= '0;
    end else if (cnt_b_q == DEB_LAST) begin
      deb_b_q <= b_sync_q;
      cnt_b_q <= '0;
    end else begin
      cnt_b_q <= cnt_b_q + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Passage FSM
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] dwell_q, dwell_d;
  logic        ent_q, sal_q, err_q;
  logic        ent_d, sal_d, err_d;
  logic        held;
  logic        timed;
  logic [1:0]  p;

  assign p     = {deb_a_q, deb_b_q};
  assign timed = (state_q != REPOSO) && (state_q != ESPERA);

  always_comb begin
    state_d = state_q;
    ent_d   = 1'b0;
    sal_d   = 1'b0;
    err_d   = 1'b0;
    held    = 1'b0;
    case (state_q)
      REPOSO:
        case (p)
          2'b00:   held = 1'b1;
          2'b10:   state_d = E1;
          2'b01:   state_d = S1;
          default: begin state_d = ESPERA; err_d = 1'b1; end
        endcase
      E1:
        case (p)
          2'b10:   held = 1'b1;
          2'b11:   state_d = E2;
          2'b00:   state_d = REPOSO;
          default: begin state_d = ESPERA; err_d = 1'b1; end
        endcase
      E2:
        case (p)
          2'b11:   held = 1'b1;
          2'b01:   state_d = E3;
          2'b10:   state_d = E1;
          default: begin state_d = ESPERA; err_d = 1'b1; end
        endcase
      E3:
        case (p)
          2'b01:   held = 1'b1;
          2'b00:   begin state_d = REPOSO; ent_d = 1'b1; end
          2'b11:   state_d = E2;
          default: begin state_d = ESPERA; err_d = 1'b1; end
        endcase
      S1:
        case (p)
          2'b01:   held = 1'b1;
          2'b11:   state_d = S2;
          2'b00:   state_d = REPOSO;
          default: begin state_d = ESPERA; err_d = 1'b1; end
        endcase
      S2:
        case (p)
          2'b11:   held = 1'b1;
          2'b10:   state_d = S3;
          2'b01:   state_d = S1;
          default: begin state_d = ESPERA; err_d = 1'b1; end
        endcase
      S3:
        case (p)
          2'b10:   held = 1'b1;
          2'b00:   begin state_d = REPOSO; sal_d = 1'b1; end
          2'b11:   state_d = S2;
          default: begin state_d = ESPERA; err_d = 1'b1; end
        endcase
      default: // ESPERA
        if (p == 2'b00) state_d = REPOSO;
    endcase

    // Timeout only fires when the pattern is unchanged; a legal move made in
    // the same cycle wins, and an illegal one already flags error above.
    if (timed && held && (dwell_q == DWELL_LAST)) begin
      state_d = ESPERA;
      err_d   = 1'b1;
    end

    if ((state_d != state_q) || !timed) dwell_d = '0;
    else                                dwell_d = dwell_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= REPOSO;
      dwell_q <= '0;
      ent_q   <= 1'b0;
      sal_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      ent_q   <= ent_d;
      sal_q   <= sal_d;
      err_q   <= err_d;
    end
  end

  assign entrada = ent_q;
  assign salida  = sal_q;
  assign error   = err_q;
  assign estado  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_detector_paso.sv
`default_nettype none
// ============================================================================
// Module      : tb_detector_paso
// Description : Self-checking bench for detector_paso (DEB_CYCLES=4,
//               TIMEOUT=20). Each scenario pushes the pulses it expects
//               ({entrada,salida,error} and cycle) into a queue; a negedge
//               monitor records every pulse the DUT produces, and the
//               scenario pops and compares both queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detector_paso;

  typedef struct {
    logic [2:0] v;
    int         c;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_a, sensor_b;
  logic       entrada, salida, error;
  logic [2:0] estado;

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t mon_ev;

  detector_paso #(.DEB_CYCLES(4), .TIMEOUT(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .sensor_a (sensor_a),
    .sensor_b (sensor_b),
    .entrada  (entrada),
    .salida   (salida),
    .error    (error),
    .estado   (estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (entrada || salida || error) begin
      mon_ev.v = {entrada, salida, error};
      mon_ev.c = cyc;
      obs_q.push_back(mon_ev);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Apply a sensor pair (called at posedge+1), return the cycle it was
  // applied in, and hold it for n cycles.
  task automatic drive(input logic a, input logic b, input int n, output int t);
    sensor_a = a;
    sensor_b = b;
    t = cyc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] v, input int c);
    ev_t e;
    e.v = v;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (estado !== 3'd0) begin errors++; $display("FAIL reset_estado got %0d expected 0", estado); end
    checks++; if (entrada !== 1'b0) begin errors++; $display("FAIL reset_entrada got %b expected 0", entrada); end
    checks++; if (salida !== 1'b0) begin errors++; $display("FAIL reset_salida got %b expected 0", salida); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b expected 0", error); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_entry;
    int t;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    drive(0, 0, 10, t);
    drive(1, 0, 10, t);
    checks++; if (estado !== 3'd1) begin errors++; $display("FAIL entry_e1 estado got %0d expected 1", estado); end
    drive(1, 1, 10, t);
    checks++; if (estado !== 3'd2) begin errors++; $display("FAIL entry_e2 estado got %0d expected 2", estado); end
    drive(0, 1, 10, t);
    checks++; if (estado !== 3'd3) begin errors++; $display("FAIL entry_e3 estado got %0d expected 3", estado); end
    push_exp(3'b100, t + 10 + 7);
    drive(0, 0, 15, t);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL entry_pulse missing: expected %b at cycle %0d", e.v, e.c); end
      else begin
        o = obs_q.pop_front();
        if (o.v !== e.v || o.c !== e.c) begin errors++; $display("FAIL entry_pulse got %b@%0d expected %b@%0d", o.v, o.c, e.v, e.c); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL entry_extra got %0d unexpected pulses expected 0", obs_q.size()); end
  endtask

  task automatic test_exit_backout;
    int t;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    drive(0, 1, 10, t);
    drive(1, 1, 10, t);
    drive(1, 0, 10, t);
    checks++; if (estado !== 3'd6) begin errors++; $display("FAIL exit_s3 estado got %0d expected 6", estado); end
    drive(0, 0, 10, t);
    push_exp(3'b010, t + 7);
    drive(1, 0, 10, t);
    drive(1, 1, 10, t);
    drive(1, 0, 10, t);
    checks++; if (estado !== 3'd1) begin errors++; $display("FAIL backout_e1 estado got %0d expected 1", estado); end
    drive(0, 0, 15, t);
    checks++; if (estado !== 3'd0) begin errors++; $display("FAIL backout_end estado got %0d expected 0", estado); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL exit_pulse missing: expected %b at cycle %0d", e.v, e.c); end
      else begin
        o = obs_q.pop_front();
        if (o.v !== e.v || o.c !== e.c) begin errors++; $display("FAIL exit_pulse got %b@%0d expected %b@%0d", o.v, o.c, e.v, e.c); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL exit_extra got %0d unexpected pulses expected 0", obs_q.size()); end
  endtask

  task automatic test_glitch;
    logic bad_deb, bad_state;
    exp_q.delete(); obs_q.delete();
    bad_deb = 1'b0;
    bad_state = 1'b0;
    sensor_b = 1'b0;
    sensor_a = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 3) sensor_a = 1'b0;
      @(posedge clk);
      #1;
      if (dut.deb_a_q !== 1'b0) bad_deb = 1'b1;
      if (estado !== 3'd0) bad_state = 1'b1;
    end
    checks++; if (bad_deb !== 1'b0) begin errors++; $display("FAIL glitch_deb deb_a changed got 1 expected 0"); end
    checks++; if (bad_state !== 1'b0) begin errors++; $display("FAIL glitch_estado left REPOSO got 1 expected 0"); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_extra got %0d unexpected pulses expected 0", obs_q.size()); end
  endtask

  task automatic test_illegal;
    int t;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    drive(1, 0, 10, t);
    drive(0, 1, 12, t);
    push_exp(3'b001, t + 7);
    checks++; if (estado !== 3'd7) begin errors++; $display("FAIL illegal_espera estado got %0d expected 7", estado); end
    drive(0, 0, 12, t);
    checks++; if (estado !== 3'd0) begin errors++; $display("FAIL illegal_release estado got %0d expected 0", estado); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL illegal_pulse missing: expected %b at cycle %0d", e.v, e.c); end
      else begin
        o = obs_q.pop_front();
        if (o.v !== e.v || o.c !== e.c) begin errors++; $display("FAIL illegal_pulse got %b@%0d expected %b@%0d", o.v, o.c, e.v, e.c); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL illegal_extra got %0d unexpected pulses expected 0", obs_q.size()); end
  endtask

  task automatic test_timeout;
    int t;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    drive(1, 0, 26, t);
    // E1 is entered 7 cycles after the edge; error follows 20 cycles later.
    push_exp(3'b001, t + 7 + 20);
    checks++; if (estado !== 3'd1) begin errors++; $display("FAIL timeout_pre estado got %0d expected 1", estado); end
    repeat (14) @(posedge clk);
    #1;
    checks++; if (estado !== 3'd7) begin errors++; $display("FAIL timeout_espera estado got %0d expected 7", estado); end
    drive(0, 0, 12, t);
    checks++; if (estado !== 3'd0) begin errors++; $display("FAIL timeout_release estado got %0d expected 0", estado); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL timeout_pulse missing: expected %b at cycle %0d", e.v, e.c); end
      else begin
        o = obs_q.pop_front();
        if (o.v !== e.v || o.c !== e.c) begin errors++; $display("FAIL timeout_pulse got %b@%0d expected %b@%0d", o.v, o.c, e.v, e.c); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL timeout_extra got %0d unexpected pulses expected 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid;
    int t;
    exp_q.delete(); obs_q.delete();
    drive(1, 0, 10, t);
    drive(1, 1, 10, t);
    checks++; if (estado !== 3'd2) begin errors++; $display("FAIL rstmid_e2 estado got %0d expected 2", estado); end
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (estado !== 3'd0) begin errors++; $display("FAIL rstmid_async estado got %0d expected 0", estado); end
    checks++; if (dut.deb_a_q !== 1'b0 || dut.deb_b_q !== 1'b0) begin errors++; $display("FAIL rstmid_deb got %b%b expected 00", dut.deb_a_q, dut.deb_b_q); end
    checks++; if ({entrada, salida, error} !== 3'b000) begin errors++; $display("FAIL rstmid_outputs got %b expected 000", {entrada, salida, error}); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 0, 20, t);
    checks++; if (estado !== 3'd0) begin errors++; $display("FAIL rstmid_after estado got %0d expected 0", estado); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_extra got %0d unexpected pulses expected 0", obs_q.size()); end
  endtask

  initial begin
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    rst = 1'b0;
    test_reset;
    test_entry;
    test_exit_backout;
    test_glitch;
    test_illegal;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
